// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order queue of predicted branches, resolved against execute outcomes.
// Latency: flush, redirect, BHT update and counters are registered, 1 cycle after the resolving edge.
// Backpressure: fetch stalls on full; a push into a full queue is taken only alongside a pop.
module branch_resolve_unit #(
    parameter int LOWER = 5,
    parameter int PC_W  = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             fetch_valid,
    input  logic [LOWER-1:0] fetch_idx,
    input  logic             fetch_pred,
    input  logic [PC_W-1:0]  fetch_target,
    input  logic [PC_W-1:0]  fetch_fallthrough,
    input  logic             ex_valid,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic             full,
    output logic             empty,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             upd_en,
    output logic [LOWER-1:0] upd_addr,
    output logic             upd_taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             underflow_err
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [LOWER-1:0] idx;
        logic             pred;
        logic [PC_W-1:0]  target;
        logic [PC_W-1:0]  ft;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        new_entry;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          pop;
    logic          push;
    logic          mispredict_now;

    assign full      = (occ == (AW+1)'(DEPTH));
    assign empty     = (occ == '0);
    assign head      = mem[rd_ptr];
    assign new_entry = '{idx: fetch_idx, pred: fetch_pred, target: fetch_target, ft: fetch_fallthrough};

    assign pop            = ex_valid & ~empty;
    assign mispredict_now = pop & ((head.pred != ex_taken) |
                                   (head.pred & ex_taken & (head.target != ex_target)));
    // Anything fetched alongside a mispredict is on the wrong path.
    assign push           = fetch_valid & (~full | pop) & ~mispredict_now;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            occ              <= '0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            upd_en           <= 1'b0;
            upd_addr         <= '0;
            upd_taken        <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
            underflow_err    <= 1'b0;
        end else begin
            if (mispredict_now) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    occ <= occ + (AW+1)'(1);
                end else if (pop && !push) begin
                    occ <= occ - (AW+1)'(1);
                end
            end

            flush  <= mispredict_now;
            upd_en <= pop;
            if (mispredict_now) begin
                redirect_pc <= ex_taken ? ex_target : head.ft;
            end
            if (pop) begin
                upd_addr  <= head.idx;
                upd_taken <= ex_taken;
            end

            if (pop && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict_now && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
            if (ex_valid && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed steps then random traffic against a queue-based model.
module tb_branch_resolve_unit;
    localparam int LOWER = 5;
    localparam int PC_W  = 64;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             fetch_valid;
    logic [LOWER-1:0] fetch_idx;
    logic             fetch_pred;
    logic [PC_W-1:0]  fetch_target;
    logic [PC_W-1:0]  fetch_fallthrough;
    logic             ex_valid;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_target;

    logic             full, empty, flush, upd_en, upd_taken, underflow_err;
    logic [PC_W-1:0]  redirect_pc;
    logic [LOWER-1:0] upd_addr;
    logic [15:0]      branch_count, mispredict_count;

    logic             s_full, s_empty, s_flush, s_upd_en, s_upd_taken, s_underflow_err;
    logic [PC_W-1:0]  s_redirect_pc;
    logic [LOWER-1:0] s_upd_addr;
    logic [2:0]       s_branch_count, s_mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_unit #(.LOWER(LOWER), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n), .fetch_valid(fetch_valid), .fetch_idx(fetch_idx),
        .fetch_pred(fetch_pred), .fetch_target(fetch_target), .fetch_fallthrough(fetch_fallthrough),
        .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
        .full(full), .empty(empty), .flush(flush), .redirect_pc(redirect_pc),
        .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken),
        .branch_count(branch_count), .mispredict_count(mispredict_count),
        .underflow_err(underflow_err)
    );

    // Narrow-counter copy on the same stimulus to exercise saturation.
    branch_resolve_unit #(.LOWER(LOWER), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(3)) dut_sat (
        .clk(clk), .arst_n(arst_n), .fetch_valid(fetch_valid), .fetch_idx(fetch_idx),
        .fetch_pred(fetch_pred), .fetch_target(fetch_target), .fetch_fallthrough(fetch_fallthrough),
        .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
        .full(s_full), .empty(s_empty), .flush(s_flush), .redirect_pc(s_redirect_pc),
        .upd_en(s_upd_en), .upd_addr(s_upd_addr), .upd_taken(s_upd_taken),
        .branch_count(s_branch_count), .mispredict_count(s_mispredict_count),
        .underflow_err(s_underflow_err)
    );

    typedef struct {
        logic [LOWER-1:0] idx;
        logic             pred;
        logic [PC_W-1:0]  target;
        logic [PC_W-1:0]  ft;
    } br_t;

    br_t             q[$];
    logic            m_flush, m_upd_en, m_upd_taken, m_uf;
    logic [PC_W-1:0] m_redir;
    logic [LOWER-1:0] m_addr;
    int              n_br, n_mis;
    int              n_assert = 0;
    int              n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return 64'((n > mx) ? mx : n);
    endfunction

    task automatic model_reset();
        q.delete();
        m_flush = 0; m_upd_en = 0; m_upd_taken = 0; m_uf = 0;
        m_redir = '0; m_addr = '0; n_br = 0; n_mis = 0;
    endtask

    task automatic chk_level();
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("s_empty", 64'(s_empty), 64'(q.size() == 0));
        chk("s_full", 64'(s_full), 64'(q.size() == DEPTH));
    endtask

    task automatic chk_regs();
        chk("flush", 64'(flush), 64'(m_flush));
        chk("redirect_pc", redirect_pc, m_redir);
        chk("upd_en", 64'(upd_en), 64'(m_upd_en));
        chk("upd_addr", 64'(upd_addr), 64'(m_addr));
        chk("upd_taken", 64'(upd_taken), 64'(m_upd_taken));
        chk("branch_count", 64'(branch_count), sat(n_br, 16));
        chk("mispredict_count", 64'(mispredict_count), sat(n_mis, 16));
        chk("underflow_err", 64'(underflow_err), 64'(m_uf));
        chk("s_flush", 64'(s_flush), 64'(m_flush));
        chk("s_redirect_pc", s_redirect_pc, m_redir);
        chk("s_upd_en", 64'(s_upd_en), 64'(m_upd_en));
        chk("s_upd_addr", 64'(s_upd_addr), 64'(m_addr));
        chk("s_upd_taken", 64'(s_upd_taken), 64'(m_upd_taken));
        chk("s_branch_count", 64'(s_branch_count), sat(n_br, 3));
        chk("s_mispredict_count", 64'(s_mispredict_count), sat(n_mis, 3));
        chk("s_underflow_err", 64'(s_underflow_err), 64'(s_underflow_err === 1'bx ? 1'b1 : m_uf));
    endtask

    // One clock: check levels, predict from the rules, clock, update model, check registers.
    task automatic tick();
        bit  pop, mis, push;
        br_t h;
        logic [PC_W-1:0] pred_next, real_next;
        chk_level();
        pop = ex_valid && (q.size() != 0);
        mis = 0;
        if (pop) begin
            h = q[0];
            pred_next = h.pred ? h.target : h.ft;
            real_next = ex_taken ? ex_target : h.ft;
            mis = (h.pred != ex_taken) || (pred_next != real_next);
        end
        push = fetch_valid && ((q.size() < DEPTH) || pop) && !mis;
        @(posedge clk);
        #1;
        if (!arst_n) begin
            model_reset();
        end else begin
            if (pop) void'(q.pop_front());
            if (mis) q.delete();
            if (push) q.push_back('{idx: fetch_idx, pred: fetch_pred, target: fetch_target, ft: fetch_fallthrough});
            m_flush  = mis;
            m_upd_en = pop;
            if (mis) m_redir = ex_taken ? ex_target : h.ft;
            if (pop) begin
                m_addr      = h.idx;
                m_upd_taken = ex_taken;
                n_br++;
            end
            if (mis) n_mis++;
            if (ex_valid && !pop) m_uf = 1;
        end
        chk_regs();
    endtask

    task automatic cyc(input bit fv, input logic [LOWER-1:0] idx, input bit pr,
                       input logic [PC_W-1:0] tg, input logic [PC_W-1:0] ft,
                       input bit ev, input bit et, input logic [PC_W-1:0] etg);
        fetch_valid = fv; fetch_idx = idx; fetch_pred = pr; fetch_target = tg; fetch_fallthrough = ft;
        ex_valid = ev; ex_taken = et; ex_target = etg;
        tick();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        arst_n = 0;
        fetch_valid = 0; fetch_idx = 0; fetch_pred = 0; fetch_target = 0; fetch_fallthrough = 0;
        ex_valid = 0; ex_taken = 0; ex_target = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk_level();
        chk_regs();
        arst_n = 1;

        // Correctly predicted taken branch.
        cyc(1, 3, 1, 64'h100, 64'h44, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 64'h100);
        idle();

        // Predicted not-taken, actually taken; younger entries dropped.
        cyc(1, 5, 0, 64'h0, 64'h48, 0, 0, 0);
        cyc(1, 6, 1, 64'h500, 64'h4c, 0, 0, 0);
        cyc(1, 7, 0, 64'h600, 64'h50, 0, 0, 0);
        cyc(1, 8, 0, 64'h700, 64'h54, 1, 1, 64'h200);
        idle();

        // Predicted taken, actually not taken.
        cyc(1, 9, 1, 64'h300, 64'h58, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 64'h300);
        idle();

        // Fill, blocked push, push alongside pop, FIFO drain with pointer wrap.
        for (int i = 0; i < DEPTH; i++) cyc(1, 5'(10 + i), 0, 64'h0, 64'(16'h60 + 4 * i), 0, 0, 0);
        cyc(1, 20, 0, 64'h0, 64'h80, 0, 0, 0);
        cyc(1, 21, 0, 64'h0, 64'h84, 1, 0, 64'h0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 0, 1, 0, 64'h0);
        idle();

        // Underflow, sticky.
        cyc(0, 0, 0, 0, 0, 1, 1, 64'h123);
        idle();
        cyc(0, 0, 0, 0, 0, 1, 0, 64'h0);

        // Reset during a pending push and pop.
        cyc(1, 2, 1, 64'h900, 64'h90, 0, 0, 0);
        arst_n = 0;
        cyc(1, 4, 1, 64'h910, 64'h94, 1, 1, 64'h900);
        arst_n = 1;
        idle();

        // Ten mispredicts saturate the narrow counter at 7.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 5'(i), 0, 64'h0, 64'(16'h200 + 4 * i), 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 1, 1, 64'h800);
        end
        idle();

        // Random traffic, mostly correct predictions so the queue fills at times.
        for (int n = 0; n < 400; n++) begin
            arst_n            = ($urandom_range(0, 63) != 0);
            fetch_valid       = 1'($urandom_range(0, 1));
            fetch_idx         = 5'($urandom_range(0, 31));
            fetch_pred        = 1'($urandom_range(0, 1));
            fetch_target      = 64'($urandom_range(1, 3)) << 8;
            fetch_fallthrough = 64'($urandom_range(1, 255)) << 2;
            ex_valid          = ($urandom_range(0, 2) == 0);
            ex_taken          = 1'($urandom_range(0, 1));
            ex_target         = 64'($urandom_range(1, 3)) << 8;
            if (q.size() != 0 && $urandom_range(0, 3) != 0) begin
                ex_taken  = q[0].pred;
                ex_target = q[0].target;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks in-flight branch predictions between fetch and execute and resolves them against actual outcomes. Fetch pushes each predicted branch (BHT index, predicted direction, predicted target, fall-through PC) into an in-order queue. Execute pops the oldest entry and reports the real outcome. The block then raises a one-cycle flush with the correct redirect PC on a mispredict, drives the update port of `branch_history_table`, and keeps saturating statistics counters.

## Interface

Parameters:
- `LOWER`, 5: BHT index width; matches `branch_history_table.LOWER`.
- `PC_W`, 64: PC / target width.
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `arst_n`  in  1  reset; synchronous, active-low. Sampled only on the rising edge of `clk`.
- `fetch_valid`  in  1  a branch/jump was fetched this cycle.
- `fetch_idx`  in  LOWER  BHT index used for its prediction.
- `fetch_pred`  in  1  predicted taken.
- `fetch_target`  in  PC_W  predicted taken target.
- `fetch_fallthrough`  in  PC_W  PC+4 of the branch.
- `ex_valid`  in  1  oldest in-flight branch resolved this cycle.
- `ex_taken`  in  1  actual outcome (was_taken | jumped).
- `ex_target`  in  PC_W  actual taken target.
- `full`  out  1  queue holds DEPTH entries.
- `empty`  out  1  queue holds 0 entries.
- `flush`  out  1  one-cycle mispredict pulse.
- `redirect_pc`  out  PC_W  correct next PC; valid while `flush`=1.
- `upd_en`  out  1  BHT update strobe; feeds BHT `en`.
- `upd_addr`  out  LOWER  feeds BHT `write_addr`.
- `upd_taken`  out  1  feeds BHT `was_taken`.
- `branch_count`  out  CNT_W  resolved branches, saturating.
- `mispredict_count`  out  CNT_W  mispredicts, saturating.
- `underflow_err`  out  1  sticky; set when `ex_valid` arrives while the queue is empty.

## Operation

Queue:
- Circular buffer with write pointer, read pointer and an occupancy counter of width log2(DEPTH)+1.
- Pointers wrap modulo DEPTH.
- `pop` = `ex_valid` & !`empty`.
- `push` = `fetch_valid` & (!`full` | `pop`) & !`mispredict_now`.
- Push into a full queue is accepted only when a pop occurs in the same cycle. Otherwise the push is dropped and fetch must stall on `full`.
- Push and pop in the same cycle leave occupancy unchanged.

Resolve (combinational on the popped head entry):
- `mispredict_now` = `pop` & ((`pred` != `ex_taken`) | (`pred` & `ex_taken` & (`target` != `ex_target`))).
- If the outcome was taken, the redirect PC is `ex_target`; otherwise it is the entry's fall-through PC.

On `mispredict_now`:
- The whole queue is cleared: pointers to 0, occupancy to 0. Every remaining entry is younger and on the wrong path.
- The same-cycle push is discarded.

Update:
- Every pop produces `upd_en`=1, `upd_addr`=entry idx, `upd_taken`=`ex_taken`, whether the prediction was correct or not.

Statistics:
- `branch_count` increments on each pop.
- `mispredict_count` increments on each `mispredict_now`.
- Both hold at all-ones (no wrap).

Errors:
- `ex_valid` with `empty`=1 performs no pop, no update and no flush, and sets `underflow_err`.
- `underflow_err` clears only on reset.

Reset (`arst_n`=0 at a clock edge):
- Pointers, occupancy, counters and `underflow_err` go to 0; `flush`=0, `upd_en`=0, `redirect_pc`=0, `upd_addr`=0, `upd_taken`=0.
- `empty`=1, `full`=0.
- Reset overrides any simultaneous push or pop.

## Timing

- `flush`, `redirect_pc`, `upd_en`, `upd_addr`, `upd_taken` and the counters are registered: 1-cycle latency from the `ex_valid` edge.
- `flush` and `upd_en` are high for exactly one cycle per event. Back-to-back pops give back-to-back `upd_en` pulses.
- `redirect_pc` and `upd_*` hold their last values when their strobe is low.
- `full` and `empty` are derived from registered occupancy and reflect state after the previous edge.
- Fetch may push in the cycle right after `flush`; that entry is the first correct-path branch.
- A pushed entry can be popped at the earliest on the cycle after its push. Bypass from push to pop in the same cycle is not supported.

## Test plan

- Reset, then push idx=3 pred=1 target=0x100 fallthrough=0x44; resolve taken with target 0x100 -> next cycle `upd_en`=1, `upd_addr`=3, `upd_taken`=1, `flush`=0, `branch_count`=1, `empty`=1.
- Push pred=0 fallthrough=0x48, then push 2 more; resolve oldest taken with target 0x200 -> `flush`=1 for one cycle, `redirect_pc`=0x200, `mispredict_count`=1, `empty`=1 afterwards (younger entries discarded).
- Push pred=1 target=0x300; resolve not-taken -> `flush`=1, `redirect_pc` = that entry's fall-through PC, `upd_taken`=0.
- Fill 4 entries -> `full`=1. A push alone is dropped (occupancy stays 4). A push with a correct-prediction pop in the same cycle is accepted (occupancy stays 4). Further pops drain in FIFO order, checking each `upd_addr`, and the pointers wrap.
- Assert `ex_valid` while empty -> `underflow_err`=1 and sticky, `upd_en`=0, counters unchanged. Drive `arst_n`=0 during a pending push/pop -> all outputs return to reset values on that edge.
- Force 2^CNT_W+2 mispredicts (small CNT_W override, e.g. 3) -> `mispredict_count` saturates at 7.
